// File: rtl/sys_bus_pkg.sv
// Shared helpers for the sys_bus crossbar and its arbiter.
package sys_bus_pkg;

    // Index width for n ports, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sys_bus_arb.sv
// Fixed-priority arbiter: lowest-index requester wins; one-hot grant plus binary index.
module sys_bus_arb
    import sys_bus_pkg::*;
#(
    parameter int N = 1,
    localparam int IdxW = idx_width(N)
) (
    input  logic [N-1:0]    i_req,
    output logic [N-1:0]    o_gnt,
    output logic [IdxW-1:0] o_idx,
    output logic            o_valid
);

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        // Descending scan so the lowest requesting index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx   = IdxW'(i);
                o_valid = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            o_gnt[i] = o_valid && (o_idx == IdxW'(i));
        end
    end

endmodule

// File: rtl/sys_bus.sv
// Single-cycle multi-host to multi-device crossbar with base/mask address decode
// and a one-cycle registered response route back to the originating host.
module sys_bus
    import sys_bus_pkg::*;
#(
    parameter int NrDevices    = 1,
    parameter int NrHosts      = 1,
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,

    input  logic [NrHosts-1:0]        host_req_i,
    output logic [NrHosts-1:0]        host_gnt_o,
    input  logic [AddressWidth-1:0]   host_addr_i    [NrHosts],
    input  logic [NrHosts-1:0]        host_we_i,
    input  logic [DataWidth/8-1:0]    host_be_i      [NrHosts],
    input  logic [DataWidth-1:0]      host_wdata_i   [NrHosts],
    output logic [NrHosts-1:0]        host_rvalid_o,
    output logic [DataWidth-1:0]      host_rdata_o   [NrHosts],
    output logic [NrHosts-1:0]        host_err_o,

    output logic [NrDevices-1:0]      device_req_o,
    output logic [AddressWidth-1:0]   device_addr_o  [NrDevices],
    output logic [NrDevices-1:0]      device_we_o,
    output logic [DataWidth/8-1:0]    device_be_o    [NrDevices],
    output logic [DataWidth-1:0]      device_wdata_o [NrDevices],
    input  logic [NrDevices-1:0]      device_rvalid_i,
    input  logic [DataWidth-1:0]      device_rdata_i [NrDevices],
    input  logic [NrDevices-1:0]      device_err_i,

    input  logic [AddressWidth-1:0]   cfg_device_addr_base [NrDevices],
    input  logic [AddressWidth-1:0]   cfg_device_addr_mask [NrDevices]
);

    localparam int HostIdxW = idx_width(NrHosts);
    localparam int DevIdxW  = idx_width(NrDevices);
    localparam int BeW      = DataWidth / 8;

    logic [NrHosts-1:0]      w_host_gnt;
    logic [HostIdxW-1:0]     w_host_idx;
    logic                    w_host_valid;

    logic [AddressWidth-1:0] w_addr;
    logic                    w_we;
    logic [BeW-1:0]          w_be;
    logic [DataWidth-1:0]    w_wdata;

    logic [DevIdxW-1:0]      w_dev_idx;
    logic                    w_dev_hit;

    logic                    r_valid;
    logic                    r_err;
    logic [HostIdxW-1:0]     r_host_idx;
    logic [DevIdxW-1:0]      r_dev_idx;

    logic                    w_rsp_rvalid;
    logic [DataWidth-1:0]    w_rsp_rdata;
    logic                    w_rsp_err;

    sys_bus_arb #(
        .N (NrHosts)
    ) u_arb (
        .i_req   (host_req_i),
        .o_gnt   (w_host_gnt),
        .o_idx   (w_host_idx),
        .o_valid (w_host_valid)
    );

    assign host_gnt_o = w_host_gnt;

    // One-hot mux of the winning host's request fields.
    always_comb begin
        w_addr  = '0;
        w_we    = 1'b0;
        w_be    = '0;
        w_wdata = '0;
        for (int h = 0; h < NrHosts; h++) begin
            if (w_host_gnt[h]) begin
                w_addr  = host_addr_i[h];
                w_we    = host_we_i[h];
                w_be    = host_be_i[h];
                w_wdata = host_wdata_i[h];
            end
        end
    end

    // Descending scan so overlapping windows resolve to the lowest device index.
    always_comb begin
        w_dev_idx = '0;
        w_dev_hit = 1'b0;
        for (int d = NrDevices - 1; d >= 0; d--) begin
            if ((w_addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]) begin
                w_dev_idx = DevIdxW'(d);
                w_dev_hit = 1'b1;
            end
        end
    end

    always_comb begin
        for (int d = 0; d < NrDevices; d++) begin
            device_req_o[d]   = w_host_valid && w_dev_hit && (w_dev_idx == DevIdxW'(d));
            device_addr_o[d]  = w_addr;
            device_we_o[d]    = w_we;
            device_be_o[d]    = w_be;
            device_wdata_o[d] = w_wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_host_idx <= '0;
            r_dev_idx  <= '0;
        end else begin
            r_valid    <= w_host_valid;
            r_err      <= w_host_valid && !w_dev_hit;
            r_host_idx <= w_host_idx;
            r_dev_idx  <= w_dev_idx;
        end
    end

    always_comb begin
        w_rsp_rvalid = 1'b0;
        w_rsp_rdata  = '0;
        w_rsp_err    = 1'b0;
        for (int d = 0; d < NrDevices; d++) begin
            if (r_dev_idx == DevIdxW'(d)) begin
                w_rsp_rvalid = device_rvalid_i[d];
                w_rsp_rdata  = device_rdata_i[d];
                w_rsp_err    = device_err_i[d];
            end
        end
    end

    // A decode error is answered by the bus itself; no device was addressed.
    always_comb begin
        for (int h = 0; h < NrHosts; h++) begin
            host_rvalid_o[h] = 1'b0;
            host_rdata_o[h]  = '0;
            host_err_o[h]    = 1'b0;
            if (r_valid && (r_host_idx == HostIdxW'(h))) begin
                if (r_err) begin
                    host_rvalid_o[h] = 1'b1;
                    host_err_o[h]    = 1'b1;
                end else begin
                    host_rvalid_o[h] = w_rsp_rvalid;
                    host_rdata_o[h]  = w_rsp_rdata;
                    host_err_o[h]    = w_rsp_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_sys_bus.sv
// Directed bench for sys_bus with two hosts and four devices (Ram, SimCtrl, Timer, Dbg).
module tb_sys_bus;

    localparam logic [31:0] DEV_DATA [4] = '{32'hDEADBEEF, 32'h51C0_0001, 32'h7173_E002, 32'h0DB6_0003};

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [1:0]  host_req_i, host_gnt_o, host_we_i, host_rvalid_o, host_err_o;
    logic [31:0] host_addr_i [2];
    logic [3:0]  host_be_i [2];
    logic [31:0] host_wdata_i [2];
    logic [31:0] host_rdata_o [2];
    logic [3:0]  device_req_o, device_we_o, device_rvalid_i, device_err_i;
    logic [31:0] device_addr_o [4];
    logic [3:0]  device_be_o [4];
    logic [31:0] device_wdata_o [4];
    logic [31:0] device_rdata_i [4];
    logic [31:0] cfg_base [4];
    logic [31:0] cfg_mask [4];
    logic [3:0]  err_inject;

    int n_vec = 0;
    int n_err = 0;

    sys_bus #(
        .NrDevices    (4),
        .NrHosts      (2),
        .DataWidth    (32),
        .AddressWidth (32)
    ) dut (
        .clk_i                (clk_i),
        .rst_ni               (rst_ni),
        .host_req_i           (host_req_i),
        .host_gnt_o           (host_gnt_o),
        .host_addr_i          (host_addr_i),
        .host_we_i            (host_we_i),
        .host_be_i            (host_be_i),
        .host_wdata_i         (host_wdata_i),
        .host_rvalid_o        (host_rvalid_o),
        .host_rdata_o         (host_rdata_o),
        .host_err_o           (host_err_o),
        .device_req_o         (device_req_o),
        .device_addr_o        (device_addr_o),
        .device_we_o          (device_we_o),
        .device_be_o          (device_be_o),
        .device_wdata_o       (device_wdata_o),
        .device_rvalid_i      (device_rvalid_i),
        .device_rdata_i       (device_rdata_i),
        .device_err_i         (device_err_i),
        .cfg_device_addr_base (cfg_base),
        .cfg_device_addr_mask (cfg_mask)
    );

    always #5 clk_i = ~clk_i;

    // One-cycle device responders with fixed per-device data.
    always @(posedge clk_i) begin
        for (int d = 0; d < 4; d++) begin
            device_rvalid_i[d] <= device_req_o[d];
            device_rdata_i[d]  <= DEV_DATA[d];
            device_err_i[d]    <= device_req_o[d] & err_inject[d];
        end
    end

    task automatic host(input int h, input logic req, input logic [31:0] addr, input logic we);
        host_req_i[h]   = req;
        host_addr_i[h]  = addr;
        host_we_i[h]    = we;
        host_be_i[h]    = 4'hF;
        host_wdata_i[h] = 32'hA5A5_0000 | 32'(h);
    endtask

    task automatic next_cycle();
        @(negedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        next_cycle();
        n_vec++; if (host_rvalid_o !== 2'b00) begin n_err++; $display("FAIL rst_rvalid: got %b want 00", host_rvalid_o); end
        n_vec++; if (host_err_o !== 2'b00) begin n_err++; $display("FAIL rst_err: got %b want 00", host_err_o); end
        n_vec++; if (host_gnt_o !== 2'b00) begin n_err++; $display("FAIL rst_gnt: got %b want 00", host_gnt_o); end
        n_vec++; if (device_req_o !== 4'b0000) begin n_err++; $display("FAIL rst_dreq: got %b want 0000", device_req_o); end
        rst_ni = 1'b1;
        next_cycle();
        n_vec++; if (host_rvalid_o !== 2'b00) begin n_err++; $display("FAIL rst_idle_rvalid: got %b want 00", host_rvalid_o); end
    endtask

    task automatic test_ram_read();
        next_cycle();
        host(0, 1'b1, 32'h0010_0010, 1'b0);
        #1;
        n_vec++; if (host_gnt_o !== 2'b01) begin n_err++; $display("FAIL ram_gnt: got %b want 01", host_gnt_o); end
        n_vec++; if (device_req_o !== 4'b0001) begin n_err++; $display("FAIL ram_dreq: got %b want 0001", device_req_o); end
        next_cycle();
        host(0, 1'b0, 32'h0, 1'b0);
        #1;
        n_vec++; if (host_rvalid_o !== 2'b01) begin n_err++; $display("FAIL ram_rvalid: got %b want 01", host_rvalid_o); end
        n_vec++; if (host_rdata_o[0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL ram_rdata: got %h want deadbeef", host_rdata_o[0]); end
        n_vec++; if (host_err_o !== 2'b00) begin n_err++; $display("FAIL ram_err: got %b want 00", host_err_o); end
        n_vec++; if (host_rdata_o[1] !== 32'h0) begin n_err++; $display("FAIL ram_rdata1: got %h want 0", host_rdata_o[1]); end
    endtask

    task automatic test_two_hosts();
        next_cycle();
        host(0, 1'b1, 32'h0002_0000, 1'b1);
        host(1, 1'b1, 32'h0004_0800, 1'b0);
        #1;
        n_vec++; if (host_gnt_o !== 2'b01) begin n_err++; $display("FAIL prio_gnt: got %b want 01", host_gnt_o); end
        n_vec++; if (device_req_o !== 4'b0010) begin n_err++; $display("FAIL prio_dreq: got %b want 0010", device_req_o); end
        n_vec++; if (device_we_o[1] !== 1'b1) begin n_err++; $display("FAIL prio_we: got %b want 1", device_we_o[1]); end
        n_vec++; if (device_addr_o[3] !== 32'h0002_0000) begin n_err++; $display("FAIL prio_fanout: got %h want 00020000", device_addr_o[3]); end
        n_vec++; if (device_wdata_o[1] !== 32'hA5A5_0000) begin n_err++; $display("FAIL prio_wdata: got %h want a5a50000", device_wdata_o[1]); end
        next_cycle();
        host(0, 1'b0, 32'h0, 1'b0);
        #1;
        n_vec++; if (host_gnt_o !== 2'b10) begin n_err++; $display("FAIL h1_gnt: got %b want 10", host_gnt_o); end
        n_vec++; if (device_req_o !== 4'b1000) begin n_err++; $display("FAIL h1_dreq: got %b want 1000", device_req_o); end
        n_vec++; if (device_we_o[3] !== 1'b0) begin n_err++; $display("FAIL h1_we: got %b want 0", device_we_o[3]); end
        n_vec++; if (host_rvalid_o !== 2'b01) begin n_err++; $display("FAIL h0_wr_rvalid: got %b want 01", host_rvalid_o); end
        n_vec++; if (host_rdata_o[0] !== DEV_DATA[1]) begin n_err++; $display("FAIL h0_wr_rdata: got %h want %h", host_rdata_o[0], DEV_DATA[1]); end
        next_cycle();
        host(1, 1'b0, 32'h0, 1'b0);
        #1;
        n_vec++; if (host_rvalid_o !== 2'b10) begin n_err++; $display("FAIL h1_rvalid: got %b want 10", host_rvalid_o); end
        n_vec++; if (host_rdata_o[1] !== DEV_DATA[3]) begin n_err++; $display("FAIL h1_rdata: got %h want %h", host_rdata_o[1], DEV_DATA[3]); end
        n_vec++; if (host_rdata_o[0] !== 32'h0) begin n_err++; $display("FAIL h1_rdata0: got %h want 0", host_rdata_o[0]); end
    endtask

    task automatic test_unmapped();
        next_cycle();
        host(1, 1'b1, 32'h0000_0500, 1'b0);
        #1;
        n_vec++; if (host_gnt_o !== 2'b10) begin n_err++; $display("FAIL unmap_gnt: got %b want 10", host_gnt_o); end
        n_vec++; if (device_req_o !== 4'b0000) begin n_err++; $display("FAIL unmap_dreq: got %b want 0000", device_req_o); end
        next_cycle();
        host(1, 1'b0, 32'h0, 1'b0);
        #1;
        n_vec++; if (host_rvalid_o !== 2'b10) begin n_err++; $display("FAIL unmap_rvalid: got %b want 10", host_rvalid_o); end
        n_vec++; if (host_err_o !== 2'b10) begin n_err++; $display("FAIL unmap_err: got %b want 10", host_err_o); end
        n_vec++; if (host_rdata_o[1] !== 32'h0) begin n_err++; $display("FAIL unmap_rdata: got %h want 0", host_rdata_o[1]); end
    endtask

    task automatic test_timer_err();
        next_cycle();
        err_inject = 4'b0100;
        host(0, 1'b1, 32'h0003_0004, 1'b0);
        #1;
        n_vec++; if (device_req_o !== 4'b0100) begin n_err++; $display("FAIL terr_dreq: got %b want 0100", device_req_o); end
        next_cycle();
        host(0, 1'b0, 32'h0, 1'b0);
        #1;
        n_vec++; if (host_rvalid_o !== 2'b01) begin n_err++; $display("FAIL terr_rvalid: got %b want 01", host_rvalid_o); end
        n_vec++; if (host_err_o !== 2'b01) begin n_err++; $display("FAIL terr_err: got %b want 01", host_err_o); end
        err_inject = 4'b0000;
    endtask

    task automatic test_back_to_back();
        next_cycle();
        host(0, 1'b1, 32'h0010_0000, 1'b0);
        #1;
        n_vec++; if (device_req_o !== 4'b0001) begin n_err++; $display("FAIL b2b_dreq0: got %b want 0001", device_req_o); end
        next_cycle();
        host(0, 1'b1, 32'h0003_0000, 1'b0);
        #1;
        n_vec++; if (device_req_o !== 4'b0100) begin n_err++; $display("FAIL b2b_dreq1: got %b want 0100", device_req_o); end
        n_vec++; if (host_rvalid_o !== 2'b01) begin n_err++; $display("FAIL b2b_rvalid0: got %b want 01", host_rvalid_o); end
        n_vec++; if (host_rdata_o[0] !== DEV_DATA[0]) begin n_err++; $display("FAIL b2b_rdata0: got %h want %h", host_rdata_o[0], DEV_DATA[0]); end
        next_cycle();
        host(0, 1'b0, 32'h0, 1'b0);
        #1;
        n_vec++; if (host_rvalid_o !== 2'b01) begin n_err++; $display("FAIL b2b_rvalid1: got %b want 01", host_rvalid_o); end
        n_vec++; if (host_rdata_o[0] !== DEV_DATA[2]) begin n_err++; $display("FAIL b2b_rdata1: got %h want %h", host_rdata_o[0], DEV_DATA[2]); end
        n_vec++; if (host_err_o !== 2'b00) begin n_err++; $display("FAIL b2b_err: got %b want 00", host_err_o); end
    endtask

    task automatic test_reset_mid();
        next_cycle();
        host(0, 1'b1, 32'h0010_0000, 1'b0);
        #1;
        n_vec++; if (host_gnt_o !== 2'b01) begin n_err++; $display("FAIL rmid_gnt: got %b want 01", host_gnt_o); end
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        host(0, 1'b0, 32'h0, 1'b0);
        #1;
        n_vec++; if (host_rvalid_o !== 2'b00) begin n_err++; $display("FAIL rmid_rvalid: got %b want 00", host_rvalid_o); end
        next_cycle();
        n_vec++; if (host_rvalid_o !== 2'b00) begin n_err++; $display("FAIL rmid_rvalid2: got %b want 00", host_rvalid_o); end
        rst_ni = 1'b1;
        next_cycle();
        n_vec++; if (host_rvalid_o !== 2'b00) begin n_err++; $display("FAIL rmid_idle_rvalid: got %b want 00", host_rvalid_o); end
        n_vec++; if (host_err_o !== 2'b00) begin n_err++; $display("FAIL rmid_idle_err: got %b want 00", host_err_o); end
        n_vec++; if (host_gnt_o !== 2'b00) begin n_err++; $display("FAIL rmid_idle_gnt: got %b want 00", host_gnt_o); end
        n_vec++; if (device_req_o !== 4'b0000) begin n_err++; $display("FAIL rmid_idle_dreq: got %b want 0000", device_req_o); end
        n_vec++; if (host_rdata_o[0] !== 32'h0) begin n_err++; $display("FAIL rmid_idle_rdata: got %h want 0", host_rdata_o[0]); end
    endtask

    initial begin
        rst_ni     = 1'b0;
        err_inject = 4'b0000;
        cfg_base   = '{32'h0010_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000};
        cfg_mask   = '{~32'h000F_FFFF, ~32'h0000_03FF, ~32'h0000_03FF, ~32'h0000_FFFF};
        host(0, 1'b0, 32'h0, 1'b0);
        host(1, 1'b0, 32'h0, 1'b0);

        test_reset();
        test_ram_read();
        test_two_hosts();
        test_unmapped();
        test_timer_err();
        test_back_to_back();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
